// File: rtl/seq_restoring_divider.sv
// Unsigned sequential restoring divider: one quotient bit per clock by trial subtraction.
// Start/busy/done handshake. Results hold until the next completion.
module seq_restoring_divider #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             dbz_reg, dbz_next;

  // The stored partial remainder is always below the divisor, so its top bit is
  // implicitly zero; only the shifted/trial values need the extra bit.
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_new;
  logic [WIDTH-1:0] r_new;

  assign r_shift = {r_reg, q_reg[WIDTH-1]};
  assign trial   = r_shift - {1'b0, d_reg};

  always_comb begin
    q_new = {q_reg[WIDTH-2:0], 1'b0};
    r_new = r_shift[WIDTH-1:0];
    if (!trial[WIDTH]) begin
      q_new = {q_reg[WIDTH-2:0], 1'b1};
      r_new = trial[WIDTH-1:0];
    end
  end

  always_comb begin
    state_next     = state_reg;
    q_next         = q_reg;
    r_next         = r_reg;
    d_next         = d_reg;
    cnt_next       = cnt_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          q_next   = dividend;
          r_next   = '0;
          d_next   = divisor;
          cnt_next = '0;
          if (divisor == '0) begin
            quotient_next  = '1;
            remainder_next = dividend;
            dbz_next       = 1'b1;
            state_next     = DONE;
          end else begin
            state_next = CALC;
          end
        end
      end
      CALC: begin
        q_next   = q_new;
        r_next   = r_new;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CNT_LAST) begin
          quotient_next  = q_new;
          remainder_next = r_new;
          dbz_next       = 1'b0;
          state_next     = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      q_reg         <= '0;
      r_reg         <= '0;
      d_reg         <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      q_reg         <= q_next;
      r_reg         <= r_next;
      d_reg         <= d_next;
      cnt_reg       <= cnt_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
    end
  end

  assign busy        = (state_reg == CALC);
  assign done        = (state_reg == DONE);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomized scoreboard bench for seq_restoring_divider: a driver queues expected
// results from plain integer division, a monitor checks each done pulse.
module tb_seq_restoring_divider;

  localparam int W = 20;
  localparam logic [W-1:0] ALL1 = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = ALL1;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Monitor: pops on every done pulse, otherwise checks outputs hold steady.
  logic [W-1:0] hq = '0, hr = '0;
  logic         hz = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hq = '0; hr = '0; hz = 1'b0;
    end else begin
      chk("busy_done_exclusive", 64'(busy & done), 64'd0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          longint unsigned recon;
          e = sb.pop_front();
          chk("quotient", 64'(quotient), 64'(e.q));
          chk("remainder", 64'(remainder), 64'(e.r));
          chk("div_by_zero", 64'(div_by_zero), 64'(e.z));
          if (!e.z) begin
            recon = longint'(quotient) * longint'(e.b) + longint'(remainder);
            chk("invariant_recon", recon, 64'(e.a));
            chk("invariant_rem_lt_div", 64'(remainder < e.b), 64'd1);
          end
          $display("op %0d / %0d -> q=%0d r=%0d dbz=%0d", e.a, e.b, quotient, remainder, div_by_zero);
        end
        hq = quotient; hr = remainder; hz = div_by_zero;
      end else begin
        chk("hold_quotient", 64'(quotient), 64'(hq));
        chk("hold_remainder", 64'(remainder), 64'(hr));
        chk("hold_dbz", 64'(div_by_zero), 64'(hz));
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_quotient"}, 64'(quotient), 64'd0);
    chk({tag, "_remainder"}, 64'(remainder), 64'd0);
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
  endtask

  // One operation; ign_at pulses a stray start at that cycle, rst_at aborts by reset.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int ign_at, input int rst_at);
    int  lat, busy_n;
    bit  seen, aborted;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    sb.push_back(model(a, b));
    #1 start = 1'b0;
    lat = 0; busy_n = 0; seen = 0; aborted = 0;
    while (!seen && !aborted && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
      if (done) seen = 1;
      if (ign_at > 0 && lat == ign_at) begin
        start = 1'b1; dividend = 9; divisor = 9;
      end else if (ign_at > 0 && lat == ign_at + 1) begin
        start = 1'b0;
      end
      if (rst_at > 0 && lat == rst_at && !seen) begin
        rst_n = 1'b0;
        void'(sb.pop_back());
        aborted = 1;
      end
    end
    if (aborted) begin
      #1 check_zero_outputs("abort");
      repeat (2) begin
        @(negedge clk);
        chk("abort_no_done", 64'(done), 64'd0);
      end
      rst_n = 1'b1;
      $display("op %0d / %0d aborted by reset at cycle %0d", a, b, rst_at);
    end else begin
      chk("done_seen", 64'(seen), 64'd1);
      chk("latency", 64'(lat), (b == 0) ? 64'd1 : 64'(W + 1));
      chk("busy_cycles", 64'(busy_n), (b == 0) ? 64'd0 : 64'(W));
    end
  endtask

  task automatic held_start(input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc, last, ndone;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    repeat (4) sb.push_back(model(a, b));
    cyc = 0; last = -1; ndone = 0;
    while (ndone < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (last >= 0) chk("turnaround", 64'(cyc - last), 64'(W + 2));
        last = cyc;
        ndone++;
        if (ndone == 4) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("held_done_count", 64'(ndone), 64'd4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_op(20'd100, 20'd7, 0, 0);
    do_op(ALL1, 20'd1, 0, 0);
    do_op(ALL1, ALL1, 0, 0);
    do_op(20'd5, 20'd9, 0, 0);
    do_op(20'd0, 20'd3, 0, 0);
    do_op(20'd1234, 20'd0, 0, 0);
    do_op(20'd10, 20'd3, 0, 0);
    do_op(20'd500, 20'd3, 5, 0);
    do_op(20'd777, 20'd5, 0, 8);
    held_start(20'd654321, 20'd123);

    for (int i = 0; i < 30; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = W'($urandom_range(0, 15));
        1:       b = W'($urandom_range(1, 1023));
        default: b = W'($urandom);
      endcase
      do_op(a, b, 0, 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
